// File: rtl/product_acc_pkg.sv
// product_acc_pkg: shared types and constants for the product accumulator.
// Provides the FSM state encoding, product width and batch-size helper.
package product_acc_pkg;

    // Width of one product from the 4x4 array multiplier.
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Largest batch a len input of len_w bits can request (len + 1).
    function automatic int max_batch(input int len_w);
        return 1 << len_w;
    endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// sat_adder: unsigned ACC_W + PROD_W bit add that clamps to all ones.
// Ports: a (accumulator), b (product), sum (clamped result), ovf (clamped).
module sat_adder
    import product_acc_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    // One extra bit catches the carry out of the accumulator width.
    logic [ACC_W:0] full;

    assign full = {1'b0, a} + (ACC_W + 1)'(b);
    assign ovf  = full[ACC_W];
    assign sum  = ovf ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a batch of len+1 multiplier products.
// Ports: clk, rst (sync, active high); p_in/p_valid/p_ready product input;
// len batch length - 1; acc_out/acc_valid/acc_ready result; ovf saturated.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] p_in,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [LEN_W-1:0]  len,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              ovf
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [LEN_W-1:0] remaining;
    logic             add_ovf;
    logic             accept;

    // Inputs are held off while a finished result waits for the consumer.
    assign p_ready = (state != HOLD);
    assign accept  = p_valid & p_ready;
    assign acc_out = acc;

    sat_adder #(
        .ACC_W (ACC_W)
    ) u_add (
        .a   (acc),
        .b   (p_in),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            acc_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        // First product starts a fresh sum; len latched here.
                        acc       <= ACC_W'(p_in);
                        ovf       <= 1'b0;
                        remaining <= len;
                        if (len == '0) begin
                            state     <= HOLD;
                            acc_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc       <= sum;
                        ovf       <= ovf | add_ovf;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state     <= HOLD;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        state     <= IDLE;
                        acc_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 4x4 array multiplier: consumes each 8-bit product p and sums a batch of LEN products into a dot-product result.
- Products enter through a valid/ready handshake; the finished sum leaves through a second valid/ready handshake with a sticky overflow flag.
- Turns the combinational multiplier into a registered multiply-accumulate datapath for the tile's I/O wrapper.

Parameters:
- ACC_W, 12, accumulator/result width in bits. Must be >= 8. 12 holds 16 x 225 = 3600 without overflow.
- LEN_W, 4, width of the batch-length input. Batch size = len + 1, range 1..2^LEN_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- p_in  in  8  product from the multiplier (unsigned).
- p_valid  in  1  p_in is valid this cycle.
- p_ready  out  1  block accepts p_in this cycle.
- len  in  LEN_W  batch length minus one; sampled only on the first product of a batch.
- acc_out  out  ACC_W  accumulated result; meaningful only while acc_valid = 1.
- acc_valid  out  1  result available.
- acc_ready  in  1  consumer takes the result.
- ovf  out  1  sticky: the current batch saturated.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state = IDLE, acc = 0, remaining = 0, acc_valid = 0, ovf = 0, acc_out = 0, p_ready = 1.
- Accept event: p_valid & p_ready. A transfer occurs only on an accept event; p_in is ignored otherwise.
- p_ready is combinational: 1 in IDLE and ACCUM, 0 in HOLD. It does not depend on p_valid.
- IDLE:
  - On accept: acc <= zero-extended p_in; ovf <= 0; remaining <= len.
  - If len == 0, go to HOLD; otherwise go to ACCUM.
- ACCUM:
  - On accept: acc <= sat(acc + p_in); remaining <= remaining - 1.
  - If remaining == 1 at that accept, go to HOLD.
  - Gaps (p_valid = 0) hold all state; no timeout.
- HOLD:
  - acc_valid = 1 (registered, asserted on the cycle of entry). acc_out and ovf stay stable.
  - On acc_ready: go to IDLE and deassert acc_valid next cycle. acc keeps its value until the next batch's first accept.
- Latency: last product accepted at edge T gives acc_valid = 1 and the correct acc_out after edge T (visible in cycle T+1).
- Throughput: minimum batch cycle = (len + 1) accepts + 1 HOLD cycle. No product is accepted in the cycle acc_ready is taken.
- Saturation: the sum is computed at ACC_W + 1 bits. If it exceeds 2^ACC_W - 1, acc <= all ones and ovf <= 1. ovf clears only at the next batch's first accept or on reset.
- Batch length: len changes mid-batch are ignored.
- acc_out = acc register in every state.
- Simultaneous events: p_valid while in HOLD is held off (p_ready = 0); no data is lost as long as the producer honours the handshake. rst has priority over every event.
- Reset mid-batch: partial sum discarded, state returns to IDLE the next cycle, no acc_valid pulse.

Decomposition:
- Shared package product_acc_pkg:
  - state enum {IDLE, ACCUM, HOLD} (2-bit encoding).
  - localparam PROD_W = 8.
  - function for max batch size.
- One sub-module: sat_adder (ACC_W-bit + PROD_W-bit unsigned add with saturation and overflow output). Purely combinational, instantiated once.
- The rest is a single FSM plus datapath registers.

Test Plan (ACC_W = 12, LEN_W = 4 unless noted):
- Basic batch: len = 3, four accepts of p_in = 225 (0xE1), back-to-back → acc_valid = 1 one cycle after the 4th accept, acc_out = 900 (0x384), ovf = 0. acc_ready = 1 → IDLE next cycle.
- Single product: len = 0, p_in = 0x8F → enter HOLD directly, acc_out = 143, acc_valid for exactly one cycle with acc_ready tied high.
- Gaps and backpressure: len = 2, products 10, 20, 30 with 2-cycle p_valid gaps; hold acc_ready = 0 for 5 cycles with p_valid = 1 → p_ready = 0 throughout HOLD, acc_out stable at 60. Release acc_ready → next product accepted only in the following cycle, starts a new sum.
- Saturation (ACC_W = 8): len = 1, p_in 225 then 225 → acc_out = 255, ovf = 1. Next batch len = 0, p_in = 5 → acc_out = 5, ovf = 0.
- len change mid-batch: start with len = 1, switch len to 7 after the first accept → result after 2 products.
- Reset mid-batch: len = 5, assert rst after 3 accepts → next cycle acc = 0, acc_valid = 0, p_ready = 1. A new batch len = 0, p_in = 7 gives 7.
